// File: rtl/miter_stim_pkg.sv
// Shared types, field layout and LFSR step for the miter stimulus driver.
package miter_stim_pkg;

  localparam int VEC_W = 64;
  localparam int Y_W   = 91;

  localparam int W0_OFF = 0;
  localparam int W0_W   = 13;
  localparam int W1_OFF = 13;
  localparam int W1_W   = 14;
  localparam int W2_OFF = 27;
  localparam int W2_W   = 14;
  localparam int W3_OFF = 41;
  localparam int W3_W   = 6;
  localparam int W4_OFF = 47;
  localparam int W4_W   = 17;

  localparam logic [VEC_W-1:0] POLY_DEF = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] q,
                                                 input logic [VEC_W-1:0] poly);
    return {q[VEC_W-2:0], ^(q & poly)};
  endfunction

endpackage

// File: rtl/miter_lfsr64.sv
// 64-bit Fibonacci LFSR with load and optional XOR input (din=0: plain LFSR, else MISR).
module miter_lfsr64
  import miter_stim_pkg::*;
#(
  parameter logic [VEC_W-1:0] POLY    = POLY_DEF,
  parameter logic [VEC_W-1:0] RST_VAL = 64'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VEC_W-1:0] seed,
  input  logic             adv,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] q
);

  logic [VEC_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (adv) begin
      q_d = lfsr_step(q_q, POLY) ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/miter_stim_driver.sv
// Pseudo-random stimulus source and y_1/y_2 result checker for the equivalence miter.
// Optional macro MITER_SIGNATURE_EN adds a MISR signature output over compared results.
module miter_stim_driver
  import miter_stim_pkg::*;
#(
  parameter int               LAT   = 2,
  parameter int               CNT_W = 32,
  parameter logic [VEC_W-1:0] POLY  = POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [VEC_W-1:0] seed,
  output logic [W0_W-1:0]  wire0,
  output logic [W1_W-1:0]  wire1,
  output logic [W2_W-1:0]  wire2,
  output logic [W3_W-1:0]  wire3,
  output logic [W4_W-1:0]  wire4,
  input  logic [Y_W-1:0]   y_1,
  input  logic [Y_W-1:0]   y_2,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] fail_index,
  output logic [VEC_W-1:0] fail_vector
`ifdef MITER_SIGNATURE_EN
  ,
  output logic [VEC_W-1:0] signature
`endif
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] fail_index_q, fail_index_d;
  logic [VEC_W-1:0] fail_vector_q, fail_vector_d;

  // Result-alignment pipe: entry i holds the vector issued i+1 cycles ago.
  logic [LAT-1:0]            pv_q, pv_d;
  logic [LAT-1:0][CNT_W-1:0] pidx_q, pidx_d;
  logic [LAT-1:0][VEC_W-1:0] pvec_q, pvec_d;

  logic [VEC_W-1:0] lfsr;
  logic [VEC_W-1:0] seed_eff;
  logic [VEC_W-1:0] wv;
  logic             start_ok;
  logic             exit_vld;
  logic             mismatch;
  logic             match;
  logic             issue;
  logic             last_issue;
  logic             others_vld;

  assign seed_eff   = (seed == '0) ? 64'h1 : seed;
  assign start_ok   = start && (state_q == IDLE || state_q == DONE || state_q == FAIL);
  assign exit_vld   = pv_q[LAT-1];
  assign mismatch   = exit_vld && (y_1 != y_2);
  assign match      = exit_vld && !mismatch;
  assign issue      = (state_q == RUN) && !mismatch;
  assign last_issue = issue && ((issued_q + CNT_W'(1)) == num_q);

  always_comb begin
    others_vld = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      others_vld = others_vld | pv_q[i];
    end
  end

  miter_lfsr64 #(.POLY(POLY), .RST_VAL(64'h1)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (seed_eff),
    .adv   (issue),
    .din   ('0),
    .q     (lfsr)
  );

`ifdef MITER_SIGNATURE_EN
  logic [VEC_W-1:0] misr_din;

  // Only RUN/DRAIN ever hold valid entries, so the MISR is frozen in DONE/FAIL.
  assign misr_din = {{(2*VEC_W-Y_W){1'b0}}, y_1[Y_W-1:VEC_W]} ^ y_1[VEC_W-1:0];

  miter_lfsr64 #(.POLY(POLY), .RST_VAL('0)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  ('0),
    .adv   (exit_vld),
    .din   (misr_din),
    .q     (signature)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start_ok) begin
          state_d = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (mismatch)        state_d = FAIL;
        else if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (mismatch)                  state_d = FAIL;
        else if (match && !others_vld) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
    fail = (state_q == FAIL);
    wv   = (state_q == RUN) ? lfsr : '0;
  end

  assign wire0       = wv[W0_OFF +: W0_W];
  assign wire1       = wv[W1_OFF +: W1_W];
  assign wire2       = wv[W2_OFF +: W2_W];
  assign wire3       = wv[W3_OFF +: W3_W];
  assign wire4       = wv[W4_OFF +: W4_W];
  assign vec_count   = vec_count_q;
  assign fail_index  = fail_index_q;
  assign fail_vector = fail_vector_q;

  always_comb begin
    issued_d      = issued_q;
    num_d         = num_q;
    vec_count_d   = vec_count_q;
    fail_index_d  = fail_index_q;
    fail_vector_d = fail_vector_q;
    for (int i = LAT - 1; i >= 1; i--) begin
      pv_d[i]   = pv_q[i-1];
      pidx_d[i] = pidx_q[i-1];
      pvec_d[i] = pvec_q[i-1];
    end
    pv_d[0]   = issue;
    pidx_d[0] = issued_q;
    pvec_d[0] = lfsr;

    if (issue) issued_d = issued_q + CNT_W'(1);
    if (match && (vec_count_q != '1)) vec_count_d = vec_count_q + CNT_W'(1);

    if (mismatch) begin
      fail_index_d  = pidx_q[LAT-1];
      fail_vector_d = pvec_q[LAT-1];
      pv_d          = '0;
    end

    if (start_ok) begin
      issued_d      = '0;
      num_d         = num_vectors;
      vec_count_d   = '0;
      fail_index_d  = '0;
      fail_vector_d = '0;
      pv_d          = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q      <= '0;
      num_q         <= '0;
      vec_count_q   <= '0;
      fail_index_q  <= '0;
      fail_vector_q <= '0;
      pv_q          <= '0;
      pidx_q        <= '0;
      pvec_q        <= '0;
    end else begin
      issued_q      <= issued_d;
      num_q         <= num_d;
      vec_count_q   <= vec_count_d;
      fail_index_q  <= fail_index_d;
      fail_vector_q <= fail_vector_d;
      pv_q          <= pv_d;
      pidx_q        <= pidx_d;
      pvec_q        <= pvec_d;
    end
  end

endmodule

// File: tb/tb_miter_stim_driver.sv
// Bench for miter_stim_driver: randomized runs against a closed-form timeline model.
module tb_miter_stim_driver;
  import miter_stim_pkg::*;

  localparam int LAT   = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [63:0]      seed = '0;
  logic [12:0]      wire0;
  logic [13:0]      wire1;
  logic [13:0]      wire2;
  logic [5:0]       wire3;
  logic [16:0]      wire4;
  logic [90:0]      y_1, y_2;
  logic             busy, done, fail;
  logic [CNT_W-1:0] vec_count, fail_index;
  logic [63:0]      fail_vector;
`ifdef MITER_SIGNATURE_EN
  logic [63:0]      signature;
`endif

  always #5 clk = ~clk;

  miter_stim_driver #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_vectors (num_vectors),
    .seed        (seed),
    .wire0       (wire0),
    .wire1       (wire1),
    .wire2       (wire2),
    .wire3       (wire3),
    .wire4       (wire4),
    .y_1         (y_1),
    .y_2         (y_2),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .vec_count   (vec_count),
    .fail_index  (fail_index),
    .fail_vector (fail_vector)
`ifdef MITER_SIGNATURE_EN
    ,
    .signature   (signature)
`endif
  );

  // Stand-in miter: y is a fixed function of the wire vector LAT cycles earlier.
  logic [63:0] wv;
  logic [LAT-1:0][63:0] hist = '0;
  int cur_r = -1000;
  int flt = -1;
  logic inj;

  function automatic logic [90:0] g(input logic [63:0] v);
    return {v[26:0], v} ^ {v, v[63:37]};
  endfunction

  assign wv  = {wire4, wire3, wire2, wire1, wire0};
  assign y_1 = g(hist[LAT-1]);
  assign inj = (flt >= 0) && (cur_r == flt + LAT);
  assign y_2 = y_1 ^ {90'd0, inj};

  always @(posedge clk) begin
    hist[0] <= wv;
    for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] model_next(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb};
  endfunction

  logic [63:0] mvec[$];

  task automatic build(input logic [63:0] sd, input int n);
    logic [63:0] s;
    mvec.delete();
    s = (sd == 64'd0) ? 64'd1 : sd;
    for (int k = 0; k < n; k++) begin
      mvec.push_back(s);
      s = model_next(s);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wires"}, wv, 64'd0);
    chk({tag, "_flags"}, {61'd0, busy, done, fail}, 64'd0);
    chk({tag, "_vec_count"}, 64'(vec_count), 64'd0);
    chk({tag, "_fail_index"}, 64'(fail_index), 64'd0);
    chk({tag, "_fail_vector"}, fail_vector, 64'd0);
`ifdef MITER_SIGNATURE_EN
    chk({tag, "_signature"}, signature, 64'd0);
`endif
  endtask

  // Expected outputs in cycle r after the start edge, from the run's N and fault index f.
  task automatic check_cycle(input int r, input int n, input int f);
    int run_end, c;
    logic e_busy, e_done, e_fail;
    logic [63:0] e_w;
    run_end = (f >= 0 && f + LAT + 1 < n) ? f + LAT + 1 : n;
    e_w     = (r < run_end) ? mvec[r] : 64'd0;
    e_fail  = (f >= 0) && (r >= f + LAT + 1);
    e_done  = (f < 0) && (n == 0 || r >= n + LAT);
    e_busy  = (n > 0) && !e_fail && !e_done;
    c = r - LAT;
    if (c < 0) c = 0;
    if (c > n) c = n;
    if (f >= 0 && c > f) c = f;
    chk("wires", wv, e_w);
    chk("busy_done_fail", {61'd0, busy, done, fail}, {61'd0, e_busy, e_done, e_fail});
    chk("vec_count", 64'(vec_count), 64'(c));
    chk("fail_index", 64'(fail_index), e_fail ? 64'(f) : 64'd0);
    chk("fail_vector", fail_vector, e_fail ? mvec[f] : 64'd0);
  endtask

  task automatic run(input logic [63:0] sd, input int n, input int f,
                     input int pulse_at, input int rst_at);
    int endr;
    build(sd, n);
    @(negedge clk);
    seed = sd;
    num_vectors = CNT_W'(n);
    start = 1'b1;
    flt = f;
    cur_r = -1000;
    @(negedge clk);
    start = 1'b0;
    num_vectors = CNT_W'($urandom);
    seed = {$urandom, $urandom};
    endr = (f >= 0) ? f + LAT + 1 : ((n == 0) ? 0 : n + LAT);
    for (int r = 0; r <= endr + 2; r++) begin
      if (r > 0) @(negedge clk);
      cur_r = r;
      if (r == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cur_r = -1000;
        flt = -1;
        return;
      end
      check_cycle(r, n, f);
      start = (r == pulse_at);
    end
    start = 1'b0;
`ifdef MITER_SIGNATURE_EN
    begin
      logic [63:0] m;
      logic [90:0] y;
      int last;
      m = 64'd0;
      last = (f >= 0) ? f : n - 1;
      for (int k = 0; k <= last; k++) begin
        y = g(mvec[k]);
        m = model_next(m) ^ ({37'd0, y[90:64]} ^ y[63:0]);
      end
      chk("signature", signature, m);
    end
`endif
    cur_r = -1000;
    flt = -1;
  endtask

  initial begin
    logic [63:0] s;
    int n, f;
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_idle");

    chk("pin_next_1", model_next(64'd1), 64'd2);
    chk("pin_next_msb", model_next(64'h8000_0000_0000_0000), 64'd1);
    chk("pin_next_c0", model_next(64'hC000_0000_0000_0000), 64'h8000_0000_0000_0000);

    run(64'd1, 4, -1, -1, -1);
    chk("pin_seq3", mvec[3], 64'd8);
    chk("n4_done", {63'd0, done}, 64'd1);
    chk("n4_vec_count", 64'(vec_count), 64'd4);

    run(64'd0, 4, -1, -1, -1);
    chk("seed0_first", mvec[0], 64'd1);
    chk("seed0_vec_count", 64'(vec_count), 64'd4);

    run({$urandom, $urandom}, 10, 6, -1, -1);
    chk("n10_fail", {63'd0, fail}, 64'd1);
    chk("n10_fail_index", 64'(fail_index), 64'd6);
    chk("n10_vec_count", 64'(vec_count), 64'd6);
    chk("n10_fail_vector", fail_vector, mvec[6]);

    run({$urandom, $urandom}, 0, -1, -1, -1);
    run({$urandom, $urandom}, 20, -1, -1, 3);
    run({$urandom, $urandom}, 5, -1, -1, -1);
    run({$urandom, $urandom}, 12, -1, 2, -1);

`ifdef MITER_SIGNATURE_EN
    begin
      logic [63:0] sig1;
      s = {$urandom, $urandom};
      run(s, 8, -1, -1, -1);
      sig1 = signature;
      run(s, 8, -1, -1, -1);
      chk("sig_repeat", signature, sig1);
      chk("sig_nonzero", {63'd0, signature != 64'd0}, 64'd1);
    end
`endif

    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 40);
      f = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      s = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      run(s, n, f, ($urandom_range(0, 3) == 0) ? 1 : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
